// File: rtl/timer_count_ctrl.sv
// Programmable 8-bit up/down timer with reload, 2^(n+1) prescaler and sticky
// overflow/underflow status. FSM: IDLE -> LOAD -> COUNT, load has priority.
module timer_count_ctrl (
  input  logic       PCLK,
  input  logic       PRESETn,
  input  logic [7:0] TCR_IN,
  input  logic [7:0] TDR_IN,
  input  logic [1:0] TSR_CLR,
  output logic [7:0] CNT_OUT,
  output logic [1:0] TSR_OUT,
  output logic       TICK_OUT,
  output logic [1:0] STATE_OUT
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOAD  = 2'b01,
    COUNT = 2'b10
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] div, div_nxt, mask;
  logic [7:0] cnt_nxt;
  logic [1:0] tsr_set, tsr_nxt;
  logic       tick;
  logic       load_req, enable, dir_down;

  assign load_req = TCR_IN[7];
  assign dir_down = TCR_IN[5];
  assign enable   = TCR_IN[4];

  always_comb begin
    mask = 4'b0001;
    case (TCR_IN[1:0])
      2'b00:   mask = 4'b0001;
      2'b01:   mask = 4'b0011;
      2'b10:   mask = 4'b0111;
      default: mask = 4'b1111;
    endcase
  end

  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE: begin
        if (load_req)    state_nxt = LOAD;
        else if (enable) state_nxt = COUNT;
        else             state_nxt = IDLE;
      end
      LOAD: begin
        if (load_req)    state_nxt = LOAD;
        else if (enable) state_nxt = COUNT;
        else             state_nxt = IDLE;
      end
      COUNT: begin
        if (load_req)    state_nxt = LOAD;
        else if (enable) state_nxt = COUNT;
        else             state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Prescaler only runs while COUNT persists, so leaving COUNT drops any partial period.
  always_comb begin
    tick    = (state == COUNT) && ((div & mask) == mask);
    div_nxt = ((state == COUNT) && (state_nxt == COUNT)) ? div + 4'd1 : '0;
  end

  always_comb begin
    cnt_nxt = CNT_OUT;
    tsr_set = '0;
    if (state == LOAD) begin
      cnt_nxt = TDR_IN;
    end else if (tick) begin
      if (dir_down) begin
        cnt_nxt    = CNT_OUT - 8'd1;
        tsr_set[1] = (CNT_OUT == 8'h00);
      end else begin
        cnt_nxt    = CNT_OUT + 8'd1;
        tsr_set[0] = (CNT_OUT == 8'hFF);
      end
    end
    tsr_nxt = (TSR_OUT & ~TSR_CLR) | tsr_set;
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state    <= IDLE;
      div      <= '0;
      CNT_OUT  <= '0;
      TSR_OUT  <= '0;
      TICK_OUT <= 1'b0;
    end else begin
      state    <= state_nxt;
      div      <= div_nxt;
      CNT_OUT  <= cnt_nxt;
      TSR_OUT  <= tsr_nxt;
      TICK_OUT <= tick;
    end
  end

  assign STATE_OUT = state;

endmodule

// File: tb/tb_timer_count_ctrl.sv
// Scoreboard bench for timer_count_ctrl: expected steps (value, status, cycle)
// are queued by the stimulus and checked by a monitor on every TICK_OUT pulse.
module tb_timer_count_ctrl;

  logic       PCLK = 1'b0;
  logic       PRESETn;
  logic [7:0] TCR_IN, TDR_IN;
  logic [1:0] TSR_CLR;
  logic [7:0] CNT_OUT;
  logic [1:0] TSR_OUT;
  logic       TICK_OUT;
  logic [1:0] STATE_OUT;

  timer_count_ctrl dut (
    .PCLK      (PCLK),
    .PRESETn   (PRESETn),
    .TCR_IN    (TCR_IN),
    .TDR_IN    (TDR_IN),
    .TSR_CLR   (TSR_CLR),
    .CNT_OUT   (CNT_OUT),
    .TSR_OUT   (TSR_OUT),
    .TICK_OUT  (TICK_OUT),
    .STATE_OUT (STATE_OUT)
  );

  always #5 PCLK = ~PCLK;

  int cyc = 0;
  always @(posedge PCLK) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] cnt;
    logic [1:0] tsr;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Monitor: every TICK_OUT pulse must match the oldest queued step.
  initial begin
    exp_t e;
    forever begin
      @(negedge PCLK);
      if (PRESETn && TICK_OUT) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_tick cyc=%0d cnt=%h tsr=%b", cyc, CNT_OUT, TSR_OUT);
        end else begin
          e = sb.pop_front();
          if (CNT_OUT !== e.cnt || TSR_OUT !== e.tsr || cyc != e.cyc)
            begin
              errors++;
              $display("FAIL tick_step got cnt=%h tsr=%b cyc=%0d exp cnt=%h tsr=%b cyc=%0d",
                       CNT_OUT, TSR_OUT, cyc, e.cnt, e.tsr, e.cyc);
            end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] cnt, input logic [1:0] tsr, input int c);
    exp_t e;
    e.cnt = cnt;
    e.tsr = tsr;
    e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) step();
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200 && sb.size() > 0; i++) @(negedge PCLK);
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain_timeout pending=%0d exp=0", sb.size());
      sb.delete();
    end
  endtask

  // From IDLE: one LOAD cycle, then tcr; b is the edge that enters COUNT.
  task automatic load_count(input logic [7:0] tdr, input logic [7:0] tcr, output int b);
    TDR_IN = tdr;
    TCR_IN = 8'h80;
    step();
    TCR_IN = tcr;
    b = cyc + 1;
  endtask

  initial begin
    int b;
    TCR_IN  = '0;
    TDR_IN  = '0;
    TSR_CLR = '0;
    PRESETn = 1'b1;
    #1 PRESETn = 1'b0;
    #2;
    chk("rst_cnt", 32'(CNT_OUT), 32'h00);
    chk("rst_tsr", 32'(TSR_OUT), 32'h0);
    chk("rst_state", 32'(STATE_OUT), 32'h0);
    chk("rst_tick", 32'(TICK_OUT), 32'h0);
    repeat (2) @(negedge PCLK);
    PRESETn = 1'b1;
    step();

    // Overflow, divide-2
    load_count(8'hFD, 8'h10, b);
    push(8'hFE, 2'b00, b + 2);
    push(8'hFF, 2'b00, b + 4);
    push(8'h00, 2'b01, b + 6);
    wait_until(b + 6);
    TCR_IN = 8'h00;
    wait_drain();
    step();
    chk("ovf_sticky", 32'(TSR_OUT), 32'h1);
    TSR_CLR = 2'b01;
    step();
    TSR_CLR = 2'b00;
    chk("clr_ovf_idle", 32'(TSR_OUT), 32'h0);

    // Underflow, divide-4
    load_count(8'h01, 8'h31, b);
    push(8'h00, 2'b00, b + 4);
    push(8'hFF, 2'b10, b + 8);
    wait_until(b + 8);
    TCR_IN = 8'h00;
    wait_drain();
    step();

    // Clear strobe collides with the wrap edge
    load_count(8'hFF, 8'h10, b);
    push(8'h00, 2'b11, b + 2);
    wait_until(b + 1);
    TSR_CLR = 2'b01;
    wait_until(b + 2);
    TSR_CLR = 2'b00;
    TCR_IN  = 8'h00;
    wait_drain();
    step();
    chk("collision_tsr", 32'(TSR_OUT), 32'h3);

    // Pause one cycle before the step, then resume
    load_count(8'h10, 8'h11, b);
    wait_until(b + 2);
    TCR_IN = 8'h01;
    wait_until(b + 3);
    chk("pause_state", 32'(STATE_OUT), 32'h0);
    chk("pause_cnt", 32'(CNT_OUT), 32'h10);
    wait_until(b + 8);
    TCR_IN = 8'h11;
    push(8'h11, 2'b11, b + 13);
    wait_until(b + 13);
    TCR_IN = 8'h00;
    wait_drain();
    step();
    TSR_CLR = 2'b11;
    step();
    TSR_CLR = 2'b00;
    chk("clr_both", 32'(TSR_OUT), 32'h0);

    // Divide-16, then load takes priority over enable
    load_count(8'h20, 8'h13, b);
    push(8'h21, 2'b00, b + 16);
    push(8'h22, 2'b00, b + 32);
    wait_until(b + 32);
    TDR_IN = 8'h77;
    TCR_IN = 8'h93;
    wait_until(b + 33);
    chk("load_prio_state", 32'(STATE_OUT), 32'h1);
    wait_until(b + 34);
    chk("load_prio_cnt", 32'(CNT_OUT), 32'h77);
    TCR_IN = 8'h00;
    step();
    wait_drain();
    step();
    chk("back_idle", 32'(STATE_OUT), 32'h0);

    // Asynchronous reset while counting
    load_count(8'hFF, 8'h10, b);
    push(8'h00, 2'b01, b + 2);
    wait_until(b + 2);
    TCR_IN = 8'h00;
    wait_drain();
    step();
    load_count(8'h5A, 8'h10, b);
    wait_until(b);
    chk("pre_rst_cnt", 32'(CNT_OUT), 32'h5A);
    chk("pre_rst_state", 32'(STATE_OUT), 32'h2);
    chk("pre_rst_tsr", 32'(TSR_OUT), 32'h1);
    #2 PRESETn = 1'b0;
    #1;
    chk("async_rst_cnt", 32'(CNT_OUT), 32'h00);
    chk("async_rst_tsr", 32'(TSR_OUT), 32'h0);
    chk("async_rst_state", 32'(STATE_OUT), 32'h0);
    chk("async_rst_tick", 32'(TICK_OUT), 32'h0);
    @(negedge PCLK);
    PRESETn = 1'b1;
    step();
    chk("release_first_edge", 32'(STATE_OUT), 32'h2);
    TCR_IN = 8'h00;
    step();
    step();
    chk("final_idle", 32'(STATE_OUT), 32'h0);
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout cyc=%0d exp=finish", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/timer_count_ctrl.md
TIMER_COUNT_CTRL -- requirements
Module: timer_count_ctrl

Interface
REQ-001 SHALL provide: PCLK  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL provide: PRESETn  in  1  asynchronous, active-low reset.
REQ-003 SHALL provide: TCR_IN  in  8  control register; [7] load, [5] direction (0 up, 1 down), [4] enable, [1:0] clock select; other bits ignored.
REQ-004 SHALL provide: TDR_IN  in  8  reload value.
REQ-005 SHALL provide: TSR_CLR  in  2  one-cycle write-1-to-clear strobe; [0] clears OVF, [1] clears UDF.
REQ-006 SHALL provide: CNT_OUT  out  8  registered counter value.
REQ-007 SHALL provide: TSR_OUT  out  2  registered sticky status; [0] OVF, [1] UDF.
REQ-008 SHALL provide: TICK_OUT  out  1  registered one-cycle pulse, high in the cycle after each edge on which CNT_OUT stepped.
REQ-009 SHALL provide: STATE_OUT  out  2  current FSM state encoding.

Function
REQ-010 SHALL implement FSM states IDLE=2'b00, LOAD=2'b01, COUNT=2'b10; 2'b11 unreachable, decoded as IDLE on next edge.
REQ-011 IDLE: TCR_IN[7]=1 -> LOAD; else TCR_IN[4]=1 -> COUNT; else stay; CNT_OUT holds.
REQ-012 LOAD: CNT_OUT <= TDR_IN every cycle in LOAD; stay while TCR_IN[7]=1; on TCR_IN[7]=0 -> COUNT if TCR_IN[4]=1, else IDLE.
REQ-013 COUNT: TCR_IN[7]=1 -> LOAD (priority over enable); else TCR_IN[4]=0 -> IDLE; else stay.
REQ-014 SHALL keep a 4-bit prescaler DIV; increments by 1 (mod 16) each cycle in COUNT; forced to 0 in IDLE and LOAD.
REQ-015 Tick condition: state COUNT and (DIV & MASK)==MASK, MASK = 4'b0001/0011/0111/1111 for TCR_IN[1:0] = 00/01/10/11 (divide 2/4/8/16).
REQ-016 On tick edge: direction 0 -> CNT_OUT+1 mod 256; direction 1 -> CNT_OUT-1 mod 256.
REQ-017 First step occurs 2^(cks+1) edges after the edge entering COUNT; subsequent steps every 2^(cks+1) edges.
REQ-018 Clock-select or direction change in COUNT SHALL take effect from the next cycle's tick evaluation; DIV not reset.
REQ-019 Up-count wrap 8'hFF->8'h00 SHALL set TSR_OUT[0]; down-count wrap 8'h00->8'hFF SHALL set TSR_OUT[1].
REQ-020 TSR_OUT bits sticky until cleared by corresponding TSR_CLR bit; set and clear in same cycle -> set wins.
REQ-021 Leaving COUNT mid-period SHALL discard partial prescale (no step, no status change).

Reset
REQ-022 PRESETn=0 SHALL immediately force: state IDLE, CNT_OUT 8'h00, TSR_OUT 2'b00, TICK_OUT 0, DIV 4'h0, STATE_OUT 2'b00.
REQ-023 After PRESETn release, first state change SHALL occur on first PCLK edge sampling TCR_IN.

Verification
REQ-024 Reset mid-count: PRESETn low while COUNT, CNT_OUT=8'h5A, TSR_OUT=2'b01 -> outputs 8'h00/2'b00/IDLE without waiting for PCLK.
REQ-025 Overflow: TDR_IN=8'hFD, TCR_IN=8'h80 one cycle then 8'h10 -> CNT_OUT FD,FE,FF,00 every 2 cycles; TSR_OUT[0]=1 at 00 and held; TICK_OUT pulse per step.
REQ-026 Underflow: TDR_IN=8'h01, load then TCR_IN=8'h31 -> CNT_OUT 01,00,FF at 4-cycle spacing; TSR_OUT[1]=1 at FF.
REQ-027 Clear/collision: TSR_CLR=2'b01 idle -> TSR_OUT[0]=0 next edge; TSR_CLR=2'b01 on wrap edge -> TSR_OUT[0] stays 1.
REQ-028 Pause/resume: TCR_IN[4] dropped one cycle before step -> IDLE, CNT_OUT unchanged, no TICK_OUT; re-enable -> first step 2^(cks+1) edges later.
REQ-029 Divide-16 and load priority: TCR_IN=8'h13 -> steps every 16 cycles; assert TCR_IN[7] in COUNT -> LOAD, CNT_OUT=TDR_IN next edge.
